// File: rtl/ls30rot_encoder_pkg.sv
// Shared LS-30 definitions: FSM states, position limit, wire-pattern and distance helpers.
// Used by both the rotary encoder and the rotation decoder.
package ls30_pkg;

  typedef enum logic [1:0] {IDLE, OVERLAP, HOLD} ls30_state_e;

  localparam logic [3:0] POS_MAX = 4'd11;

  function automatic logic [3:0] ls30_single(input logic [3:0] pos);
    return 4'b0001 << pos[1:0];
  endfunction

  // Forward (CW) distance from pos to target, modulo 12.
  function automatic logic [3:0] ls30_dist(input logic [3:0] target, input logic [3:0] pos);
    logic [4:0] d;
    d = {1'b0, target} + 5'd12 - {1'b0, pos};
    if (d >= 5'd12) d = d - 5'd12;
    return d[3:0];
  endfunction

endpackage

// File: rtl/ls30rot_encoder_if.sv
// Controller-side bus of the LS-30 encoder.
// The step_cw/step_ccw pulses exist only when LS30_ENC_STEP_EN is defined.
interface ls30rot_encoder_if;
  logic [3:0] target_pos;
  logic       target_load;
`ifdef LS30_ENC_STEP_EN
  logic       step_cw;
  logic       step_ccw;
`endif
  logic [3:0] ls30_n;
  logic [3:0] pos;
  logic       busy;

  modport master (
`ifdef LS30_ENC_STEP_EN
    output step_cw,
    output step_ccw,
`endif
    output target_pos,
    output target_load,
    input  ls30_n,
    input  pos,
    input  busy
  );

  modport slave (
`ifdef LS30_ENC_STEP_EN
    input  step_cw,
    input  step_ccw,
`endif
    input  target_pos,
    input  target_load,
    output ls30_n,
    output pos,
    output busy
  );
endinterface

// File: rtl/ls30rot_encoder_phase_timer.sv
// Loadable 16-bit down-counter; o_done pulses once when a loaded count has expired.
// Loading with N-1 makes o_done arrive N cycles after the load edge.
module ls30_phase_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  output logic        o_done
);

  logic [15:0] r_cnt;
  logic        r_run;

  assign o_done = r_run && (r_cnt == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 16'd0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
      r_run <= 1'b1;
    end else if (o_done) begin
      r_run <= 1'b0;
    end else if (r_run) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

endmodule

// File: rtl/ls30rot_encoder.sv
// LS-30 rotary encoder: steps the 4-wire active-low pattern one detent at a time toward target.
// Define LS30_ENC_STEP_EN to add relative step_cw/step_ccw target nudges.
module ls30rot_encoder #(
  parameter logic [15:0] OVL_CYC  = 16'd1000,
  parameter logic [15:0] HOLD_CYC = 16'd2000
) (
  input  logic               clk,
  input  logic               reset,
  ls30rot_encoder_if.slave   bus
);
  import ls30_pkg::*;

  ls30_state_e r_state;
  logic [3:0]  r_target;
  logic [3:0]  r_pos;
  logic [3:0]  r_next;
  logic [3:0]  r_ls30_n;
  logic        r_busy;
  logic [3:0]  r_dist_p1;
  logic        w_cw;
  logic [3:0]  w_q;
  logic        w_start;
  logic        w_done;
  logic        w_tmr_load;
  logic [15:0] w_tmr_val;

  // Target register; an out-of-range load is swallowed and still outranks a step pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_target <= POS_MAX;
    end else if (bus.target_load) begin
      if (bus.target_pos <= POS_MAX) r_target <= bus.target_pos;
    end
`ifdef LS30_ENC_STEP_EN
    else if (bus.step_cw && !bus.step_ccw) begin
      r_target <= (r_target == POS_MAX) ? 4'd0 : r_target + 4'd1;
    end else if (bus.step_ccw && !bus.step_cw) begin
      r_target <= (r_target == 4'd0) ? POS_MAX : r_target - 4'd1;
    end
`endif
  end

  // Stage p1: registered distance, giving the IDLE decision one cycle after target_r settles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_dist_p1 <= 4'd0;
    else       r_dist_p1 <= ls30_dist(r_target, r_pos);
  end

  assign w_cw    = (r_dist_p1 <= 4'd6);
  assign w_q     = w_cw ? ((r_pos == POS_MAX) ? 4'd0 : r_pos + 4'd1)
                        : ((r_pos == 4'd0) ? POS_MAX : r_pos - 4'd1);
  assign w_start = (r_state == IDLE) && (r_dist_p1 != 4'd0);

  assign w_tmr_load = w_start || ((r_state == OVERLAP) && w_done);
  assign w_tmr_val  = (r_state == IDLE) ? (OVL_CYC - 16'd1) : (HOLD_CYC - 16'd1);

  ls30_phase_timer u_timer (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_done)
  );

  // Stage p2: state and all outputs registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_pos    <= POS_MAX;
      r_next   <= POS_MAX;
      r_ls30_n <= 4'b0111;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_next   <= w_q;
            r_state  <= OVERLAP;
            r_ls30_n <= ~(ls30_single(r_pos) | ls30_single(w_q));
            r_busy   <= 1'b1;
          end else begin
            r_ls30_n <= ~ls30_single(r_pos);
            r_busy   <= 1'b0;
          end
        end
        OVERLAP: begin
          if (w_done) begin
            r_pos    <= r_next;
            r_state  <= HOLD;
            r_ls30_n <= ~ls30_single(r_next);
          end
        end
        HOLD: begin
          if (w_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ls30_n = r_ls30_n;
  assign bus.pos    = r_pos;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_ls30rot_encoder.sv
// Bench for ls30rot_encoder with OVL_CYC=4, HOLD_CYC=8; step-pulse cases need LS30_ENC_STEP_EN.
// Expected per-cycle {ls30_n,pos,busy} traces are built from the detent-walk rules.
module tb_ls30rot_encoder;
  localparam int OVL  = 4;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   mpos     = 11;
  logic [8:0] exp_q[$];

  ls30rot_encoder_if bus();

  ls30rot_encoder #(.OVL_CYC(16'd4), .HOLD_CYC(16'd8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] single(input int p);
    return 4'(1 << (p % 4));
  endfunction

  function automatic logic [8:0] smp(input logic [3:0] pat, input int p, input bit b);
    return {~pat, 4'(p), b};
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed={ls30_n,pos,busy}=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Walk from mpos: the first step heads for first_t, all later steps for final_t.
  task automatic build(input int first_t, input int final_t);
    int p, t, d, q;
    p = mpos;
    t = first_t;
    exp_q.delete();
    exp_q.push_back(smp(single(p), p, 1'b0));
    exp_q.push_back(smp(single(p), p, 1'b0));
    for (int s = 0; s < 12; s++) begin
      d = (t - p + 12) % 12;
      if (d == 0) break;
      q = (d <= 6) ? (p + 1) % 12 : (p + 11) % 12;
      repeat (OVL) exp_q.push_back(smp(single(p) | single(q), p, 1'b1));
      p = q;
      repeat (HOLD) exp_q.push_back(smp(single(p), p, 1'b1));
      exp_q.push_back(smp(single(p), p, 1'b0));
      t = final_t;
    end
    repeat (3) exp_q.push_back(smp(single(p), p, 1'b0));
    mpos = p;
  endtask

  task automatic clear_act();
    bus.target_load = 1'b0;
`ifdef LS30_ENC_STEP_EN
    bus.step_cw  = 1'b0;
    bus.step_ccw = 1'b0;
`endif
  endtask

  // kind: 0 none, 1 load, 2 cw, 3 ccw, 4 cw+ccw, 5 load+ccw
  task automatic set_act(input int kind, input int val);
    clear_act();
    bus.target_pos = 4'(val);
    if (kind == 1 || kind == 5) bus.target_load = 1'b1;
`ifdef LS30_ENC_STEP_EN
    if (kind == 2 || kind == 4) bus.step_cw = 1'b1;
    if (kind == 3 || kind == 4 || kind == 5) bus.step_ccw = 1'b1;
`endif
  endtask

  task automatic run(input string tag, input int kind1, input int val1, input int kind2,
                     input int val2, input int k2, input int first_t, input int final_t);
    build(first_t, final_t);
    set_act(kind1, val1);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      clear_act();
      check($sformatf("%s[%0d]", tag, k), {bus.ls30_n, bus.pos, bus.busy}, exp_q[k]);
      if (k == k2) set_act(kind2, val2);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_act();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    mpos = 11;
  endtask

  initial begin
    int v, ft, q;
    reset = 1'b1;
    bus.target_pos = 4'd0;
    clear_act();
    repeat (3) @(negedge clk);
    check("reset_state", {bus.ls30_n, bus.pos, bus.busy}, 9'b0111_1011_0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check($sformatf("idle100[%0d]", i), {bus.ls30_n, bus.pos, bus.busy}, 9'b0111_1011_0);
    end

    run("load0", 1, 0, 0, 0, -1, 0, 0);
    do_reset();
    run("load8_ccw", 1, 8, 0, 0, -1, 8, 8);
    do_reset();
    run("load5_tie", 1, 5, 0, 0, -1, 5, 5);
    run("load14_ignored", 1, 14, 0, 0, -1, mpos, mpos);
    do_reset();
    run("retarget", 1, 8, 1, 3, 3, 8, 3);

    for (int i = 0; i < 10; i++) begin
      v  = int'($urandom_range(0, 15));
      ft = (v <= 11) ? v : mpos;
      run($sformatf("rand%0d_t%0d", i, v), 1, v, 0, 0, -1, ft, ft);
    end

    q = (mpos + 1) % 12;
    set_act(1, (mpos + 3) % 12);
    for (int k = 0; k <= 2 + OVL + 2; k++) begin
      @(negedge clk);
      clear_act();
    end
    check("in_hold", {bus.ls30_n, bus.pos, bus.busy}, smp(single(q), q, 1'b1));
    reset = 1'b1;
    #1;
    check("async_reset", {bus.ls30_n, bus.pos, bus.busy}, 9'b0111_1011_0);
    @(negedge clk);
    reset = 1'b0;
    mpos = 11;
    run("post_reset", 0, 0, 0, 0, -1, 11, 11);

`ifdef LS30_ENC_STEP_EN
    do_reset();
    run("step_cw2", 2, 0, 2, 0, 0, 0, 1);
    run("step_both", 4, 0, 0, 0, -1, mpos, mpos);
    run("load6_ccw", 5, 6, 0, 0, -1, 6, 6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ls30rot_encoder.md
# ls30rot_encoder

Generates LS-30 rotary-joystick wire patterns from an absolute rotation target. It is the transmit-side counterpart of the LS-30 rotation decoder. A modern controller (analog stick angle, mouse, or buttons) supplies a position in 0..11, and the block steps the emulated 4-wire grouped LS-30 output one detent at a time toward that target. Every detent transition includes the two-switch overlap phase the game hardware and the decoder rely on. It sits between the input-mapping logic and the core's rotary input pins.

## Interface
- OVL_CYC, 16'd1000: cycles the two-adjacent-switch overlap pattern is held; min 1.
- HOLD_CYC, 16'd2000: cycles the single-switch pattern is held after a step; min 1.
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- target_pos  in  4  requested absolute position, 0..11; values 12..15 are ignored.
- target_load  in  1  single-cycle strobe; latches target_pos.
- ls30_n  out  4  active-low grouped wires, bit k = group k, where bit0=(9,5,1), bit1=(10,6,2), bit2=(11,7,3), bit3=(12,8,4).
- pos  out  4  current emulated position, 0..11.
- busy  out  1  high while in OVERLAP or HOLD.

## Operation
- Positive-logic pattern for position p is single(p) = 1 << (p mod 4). Output ls30_n = ~pattern.
- A CW step increments p with wrap 11→0. A CCW step decrements p with wrap 0→11.
- The overlap pattern for a step from p to q is single(p) | single(q).
- Example: 11→0 CW gives 1000 → 1001 → 0001.
- Direction rule, evaluated in IDLE: d = (target_r − pos) mod 12, computed in 5-bit arithmetic and reduced to 0..11.
  - d=0: stay in IDLE.
  - d=1..6: CW. The tie at d=6 resolves CW.
  - d=7..11: CCW.
- FSM states:
  - IDLE: pattern = single(pos). If d≠0, go to OVERLAP and latch next position q.
  - OVERLAP: pattern = single(pos)|single(q) for OVL_CYC cycles. Then pos←q and go to HOLD.
  - HOLD: pattern = single(pos) for HOLD_CYC cycles. Then go to IDLE.
- Retargeting mid-step: target_r updates immediately. The step in progress always completes through OVERLAP and HOLD. The new direction is computed in the next IDLE cycle.
- target_load with target_pos>11: target_r is unchanged.
- Reset values: target_r=11, pos=11, ls30_n=4'b0111, busy=0, state=IDLE, timer=0.
- Reset asserted mid-operation aborts the step immediately; there is no partial overlap retention.

## Timing
- All outputs are registered and come from the FSM/pos registers. There is no combinational path from inputs to outputs.
- target_load sampled at edge N: target_r is valid after N. The IDLE decision happens in cycle N+1. At edge N+2, state=OVERLAP and ls30_n shows the overlap pattern, with busy=1.
- The overlap pattern is visible for exactly OVL_CYC cycles. pos and the single pattern change on the same edge. HOLD lasts exactly HOLD_CYC cycles, followed by one IDLE cycle (busy=0).
- Step period = OVL_CYC + HOLD_CYC + 1 cycles.
- An n-step move completes n·(OVL_CYC+HOLD_CYC+1) cycles after entering the first OVERLAP, minus the final IDLE cycle.

## Configuration
- LS30_ENC_STEP_EN defined: adds inputs step_cw and step_ccw (1 bit, single-cycle pulses).
  - Each pulse sets target_r ← (target_r ± 1) mod 12.
  - Both pulses asserted in the same cycle: ignored.
  - target_load in the same cycle as a step pulse: target_load wins.
- LS30_ENC_STEP_EN undefined: those ports do not exist. target_r changes only via target_load.

## Structure
- Package ls30_pkg holds:
  - state enum {IDLE, OVERLAP, HOLD}
  - POS_MAX=4'd11
  - function ls30_single(pos) returning the 4-bit one-hot pattern
  - function ls30_dist(target, pos) returning d
- The decoder shares this package.
- Sub-module ls30_phase_timer: 16-bit loadable down-counter with load value and a done pulse. It is loaded with OVL_CYC−1 or HOLD_CYC−1.

## Test plan
All scenarios use OVL_CYC=4 and HOLD_CYC=8.
- Reset release → ls30_n=0111, pos=11, busy=0; no output change for 100 cycles with no load.
- Load 0 from 11 → ls30_n=0110 for 4 cycles, then 1110 with pos=0. busy falls 8 cycles later.
- Load 8 from 11 → CCW, 3 steps. Overlaps are 1100, 0110, 0011 (positive logic), with pos sequence 10, 9, 8. Completes in 3×13−1 cycles.
- Load 5 from 11 (tie, d=6) → 6 CW steps, pos 0..5. Load 14 → ignored, no movement.
- Load 3 at cycle 2 of OVERLAP on the way to 8 → the current step finishes; the next steps go CW toward 3. Reset asserted in HOLD → outputs return to reset values asynchronously.
- With LS30_ENC_STEP_EN: step_cw ×2 from reset → pos reaches 1. step_cw and step_ccw in the same cycle → no change. target_load=6 together with step_ccw → target 6.
